// File: rtl/multiplicador_seq_param_if.sv
// ---------------------------------------------------------------------------
// multiplicador_seq_param_if
//   Operation bus of the sequential multiplier. Groups the start request,
//   mode and operands (master -> multiplier) with the status and result
//   (multiplier -> master). Clock and reset are not part of the bundle.
//
//   St            start request, sampled only while the multiplier is idle
//   Signed_mode   1 = two's-complement operands, 0 = unsigned
//   Multiplicando operand A, W bits
//   Multiplicador operand B, W bits
//   Idle          multiplier is waiting for St
//   Done          one-cycle pulse, Produto is new in this cycle
//   Produto       last completed product, 2W bits, held between completions
// ---------------------------------------------------------------------------
interface multiplicador_seq_param_if #(
  parameter int unsigned W = 16
);
  logic             St;
  logic             Signed_mode;
  logic [W-1:0]     Multiplicando;
  logic [W-1:0]     Multiplicador;
  logic             Idle;
  logic             Done;
  logic [2*W-1:0]   Produto;

  modport master (
    output St,
    output Signed_mode,
    output Multiplicando,
    output Multiplicador,
    input  Idle,
    input  Done,
    input  Produto
  );

  modport slave (
    input  St,
    input  Signed_mode,
    input  Multiplicando,
    input  Multiplicador,
    output Idle,
    output Done,
    output Produto
  );
endinterface

// File: rtl/multiplicador_seq_param.sv
// ---------------------------------------------------------------------------
// multiplicador_seq_param
//   Parametrised shift-add multiplier for the MULT/MULTU path. Operands and
//   mode are captured on the start edge; W iterations of shift-add on the
//   magnitudes follow, then one fix-up edge applies the sign and writes the
//   held product register. Capture to Idle takes W+2 cycles.
//
//   Clk    clock, rising edge
//   Reset  asynchronous reset, active-high; aborts any running operation
//   bus    slave side of multiplicador_seq_param_if (St, Signed_mode,
//          Multiplicando, Multiplicador in; Idle, Done, Produto out)
//   W      operand width, 2..32; product is 2W bits
// ---------------------------------------------------------------------------
module multiplicador_seq_param #(
  parameter int unsigned W = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  multiplicador_seq_param_if.slave  bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W:0]    acc;       // 2W+1 bits: keeps the carry of the upper-half add
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic            sign;
  logic [2*W-1:0]  produto_q;
  logic            idle_q;
  logic            done_q;

  logic [W-1:0]    a_in;
  logic [W-1:0]    b_in;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            sign_in;
  logic [2*W:0]    partial;

  assign a_in = bus.Multiplicando;
  assign b_in = bus.Multiplicador;

  // Magnitudes of the incoming operands. Negating -2^(W-1) in W bits yields
  // 2^(W-1), which is the correct unsigned magnitude, so no special case.
  always_comb begin
    a_mag   = a_in;
    b_mag   = b_in;
    sign_in = 1'b0;
    if (bus.Signed_mode) begin
      if (a_in[W-1]) a_mag = -a_in;
      if (b_in[W-1]) b_mag = -b_in;
      sign_in = a_in[W-1] ^ b_in[W-1];
    end
  end

  // One iteration's conditional add of the multiplicand into the upper half.
  // The upper half is below 2^W before the add, so the sum fits in W+1 bits.
  always_comb begin
    partial = acc;
    if (mplier[0]) begin
      partial = acc + {1'b0, mcand, {W{1'b0}}};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      sign      <= 1'b0;
      produto_q <= '0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.St) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            sign   <= sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_CALC;
            idle_q <= 1'b0;
          end
        end

        S_CALC: begin
          acc    <= partial >> 1;
          mplier <= mplier >> 1;
          if (cnt == CW'(W - 1)) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FIX: begin
          if (sign) begin
            produto_q <= -acc[2*W-1:0];
          end else begin
            produto_q <= acc[2*W-1:0];
          end
          state  <= S_DONE;
          done_q <= 1'b1;
        end

        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          idle_q <= 1'b1;
        end

        default: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Idle    = idle_q;
  assign bus.Done    = done_q;
  assign bus.Produto = produto_q;

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// ---------------------------------------------------------------------------
// tb_multiplicador_seq_param
//   Bench for two instances of multiplicador_seq_param (W=16 and W=8):
//   directed vector table, a two-mode boundary sweep on W=16, a mid-operation
//   busy/stability sequence and an asynchronous reset abort.
// ---------------------------------------------------------------------------
module tb_multiplicador_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16;
  logic rst8;

  multiplicador_seq_param_if #(.W(16)) bus16 ();
  multiplicador_seq_param_if #(.W(8))  bus8 ();

  multiplicador_seq_param #(.W(16)) dut16 (
    .Clk   (clk),
    .Reset (rst16),
    .bus   (bus16)
  );

  multiplicador_seq_param #(.W(8)) dut8 (
    .Clk   (clk),
    .Reset (rst8),
    .bus   (bus8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          w8;
    logic        m;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic st, input logic m,
                       input logic [15:0] a, input logic [15:0] b);
    if (w8) begin
      bus8.St            = st;
      bus8.Signed_mode   = m;
      bus8.Multiplicando = a[7:0];
      bus8.Multiplicador = b[7:0];
    end else begin
      bus16.St            = st;
      bus16.Signed_mode   = m;
      bus16.Multiplicando = a;
      bus16.Multiplicador = b;
    end
  endtask

  function automatic logic get_idle(input bit w8);
    return w8 ? bus8.Idle : bus16.Idle;
  endfunction

  function automatic logic get_done(input bit w8);
    return w8 ? bus8.Done : bus16.Done;
  endfunction

  function automatic logic [31:0] get_prod(input bit w8);
    return w8 ? {16'h0000, bus8.Produto} : bus16.Produto;
  endfunction

  // One complete operation. Edge numbers count from the capture edge (0).
  // poke: from edge 3 on, hold St high with different operands/mode until
  // Done is seen, which must neither restart nor disturb the operation.
  task automatic run_op(input bit w8, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp,
                        input string name, input bit poke);
    int          wd;
    logic [31:0] prev;
    int          dn;
    int          dedge;
    int          iedge;
    bit          stable;
    bit          both;
    wd = w8 ? 8 : 16;
    dn = 0; dedge = -1; iedge = -1; stable = 1'b1; both = 1'b0;
    @(negedge clk);
    chk({name, "/idle_before"}, 32'(get_idle(w8)), 32'd1);
    prev = get_prod(w8);
    drive(w8, 1'b1, m, a, b);
    @(posedge clk);
    #1;
    drive(w8, 1'b0, ~m, ~a, ~b);
    for (int n = 1; n <= 40; n++) begin
      if (poke && n == 3) drive(w8, 1'b1, ~m, a ^ 16'h00FF, b + 16'd1);
      @(posedge clk);
      #1;
      if (get_done(w8) && get_idle(w8)) both = 1'b1;
      if (get_done(w8)) begin
        dn++;
        if (dedge < 0) begin
          dedge = n;
          chk({name, "/prod_at_done"}, get_prod(w8), exp);
        end
        drive(w8, 1'b0, m, a, b);
      end else if (dedge < 0 && get_prod(w8) !== prev) begin
        stable = 1'b0;
      end
      if (get_idle(w8)) begin
        iedge = n;
        break;
      end
    end
    chk({name, "/done_count"}, 32'(dn), 32'd1);
    chk({name, "/done_edge"}, 32'(dedge), 32'(wd + 1));
    chk({name, "/idle_edge"}, 32'(iedge), 32'(wd + 2));
    chk({name, "/prod_held"}, 32'(stable), 32'd1);
    chk({name, "/idle_done_excl"}, 32'(both), 32'd0);
    chk({name, "/prod_after"}, get_prod(w8), exp);
  endtask

  vec_t tbl[$];

  initial begin
    logic [15:0] vals [8];
    int          dn;

    tbl.push_back('{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    tbl.push_back('{1'b0, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1});
    tbl.push_back('{1'b0, 1'b1, 16'h8000, 16'h8000, 32'h40000000});
    tbl.push_back('{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001});
    tbl.push_back('{1'b0, 1'b0, 16'h0003, 16'h0005, 32'h0000000F});
    tbl.push_back('{1'b0, 1'b1, 16'h0003, 16'hFFFB, 32'hFFFFFFF1});
    tbl.push_back('{1'b0, 1'b0, 16'h8000, 16'h8000, 32'h40000000});
    tbl.push_back('{1'b0, 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000});
    tbl.push_back('{1'b0, 1'b0, 16'h1234, 16'h0000, 32'h00000000});
    tbl.push_back('{1'b1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01});
    tbl.push_back('{1'b1, 1'b1, 16'h0080, 16'h007F, 32'h0000C080});
    tbl.push_back('{1'b1, 1'b1, 16'h00FF, 16'h00FF, 32'h00000001});
    tbl.push_back('{1'b1, 1'b0, 16'h0002, 16'h0003, 32'h00000006});

    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst16 = 1'b1;
    rst8  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16/idle", 32'(bus16.Idle), 32'd1);
    chk("reset16/done", 32'(bus16.Done), 32'd0);
    chk("reset16/prod", bus16.Produto, 32'd0);
    chk("reset8/idle", 32'(bus8.Idle), 32'd1);
    chk("reset8/prod", {16'h0000, bus8.Produto}, 32'd0);
    @(negedge clk);
    rst16 = 1'b0;
    rst8  = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].w8, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].exp,
             $sformatf("vec%0d", i), 1'b0);
    end

    // Boundary sweep against a reference product in both modes.
    vals = '{16'd0, 16'd1, 16'd65530, 16'd65531, 16'd65532, 16'd65533, 16'd65534, 16'd65535};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          logic [15:0] a;
          logic [15:0] b;
          int          sa;
          int          sb;
          logic [31:0] ua;
          logic [31:0] ub;
          logic [31:0] exp;
          a  = vals[i];
          b  = vals[j];
          sa = $signed(a);
          sb = $signed(b);
          ua = {16'h0000, a};
          ub = {16'h0000, b};
          exp = (m == 1) ? 32'(sa * sb) : ua * ub;
          run_op(1'b0, m[0], a, b, exp, $sformatf("sweep_m%0d_%0d_%0d", m, i, j), 1'b0);
        end
      end
    end

    // St, operand and mode changes while busy must not affect the operation.
    run_op(1'b0, 1'b0, 16'h0003, 16'h0005, 32'h0000000F, "busy16", 1'b1);
    run_op(1'b1, 1'b1, 16'h0080, 16'h007F, 32'h0000C080, "busy8", 1'b1);

    // Asynchronous reset during the fifth CALC cycle, off the clock edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0010);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (5) @(posedge clk);
    #2;
    rst16 = 1'b1;
    #1;
    chk("abort/idle", 32'(bus16.Idle), 32'd1);
    chk("abort/done", 32'(bus16.Done), 32'd0);
    chk("abort/prod", bus16.Produto, 32'd0);
    #1;
    rst16 = 1'b0;
    dn = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (bus16.Done) dn++;
    end
    chk("abort/no_done", 32'(dn), 32'd0);
    run_op(1'b0, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplicador_seq_param.md
Name: multiplicador_seq_param

Overview:
- Parametrised sequential shift-add multiplier; next generation of the fixed 16-bit unit in the MIPS_CPU multiply path.
- Operand width is generic.
- Adds a per-operation signed/unsigned mode, an operand capture register, and a held product register.
- Sits behind the MIPS MULT/MULTU control; the result feeds HI/LO.

Parameters:
- W, 16, operand width in bits; legal range 2..32; product width is 2W.

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous reset, active-high
- St  in  1  start request; sampled only in IDLE
- Signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with St
- Multiplicando  in  W  operand A; captured with St
- Multiplicador  in  W  operand B; captured with St
- Idle  out  1  high while in IDLE
- Done  out  1  single-cycle pulse; Produto is valid and new in this cycle
- Produto  out  2W  last completed product; held until the next completion

Behaviour:
- States: IDLE, CALC, FIX, DONE. Encoding is free.
- Reset (asynchronous, any state):
  - state = IDLE, Idle = 1, Done = 0, Produto = 0.
  - Iteration counter, accumulator, captured operands and sign flag all = 0.
  - Reset mid-operation aborts it. No Done is produced.
- IDLE:
  - Idle = 1.
  - On an edge with St = 1: capture both operands and Signed_mode, then go to CALC.
  - Signed_mode = 1: store |A| and |B| as W-bit unsigned values, and store sign = A[W-1] xor B[W-1].
    - |-2^(W-1)| = 2^(W-1) fits in W unsigned bits. No overflow special case.
  - Signed_mode = 0: store operands unchanged; sign = 0.
- CALC:
  - Exactly W edges, one multiplier bit per edge, LSB first.
  - Each edge: if the current multiplier bit is 1, add the multiplicand into the upper half of the 2W+1-bit accumulator (carry kept). Then shift the accumulator right by 1.
  - Counter runs 0..W-1. Leave CALC on the edge where the counter = W-1.
- FIX:
  - One edge.
  - Result = accumulator[2W-1:0], negated (two's complement, 2W bits) if sign = 1.
  - Result is written to Produto. Go to DONE.
- DONE:
  - Done = 1, Idle = 0, for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- Latency:
  - Capture edge = edge 0.
  - Produto updates at edge W+1.
  - Done is high between edges W+1 and W+2.
  - Idle returns after edge W+2.
  - Total: W+2 cycles from capture to Idle (18 for W=16).
- Produto:
  - Changes only at the FIX-to-DONE edge or on reset.
  - Stable throughout CALC, so the previous result stays readable.
- St while not in IDLE: ignored, including in DONE.
  - St held continuously gives back-to-back operations, each separated by one IDLE cycle.
- Operand or Signed_mode changes after the capture edge have no effect on the running operation.
- Idle and Done are never both 1.
- Idle and Done are decoded from the registered state. No combinational path from inputs to outputs.

Test Plan:
- W=16, Signed_mode=0, A=65535, B=65535, St pulse one cycle:
  - Done at edge 17 after capture.
  - Produto = 32'hFFFE0001.
  - Idle high again after edge 18.
- W=16, Signed_mode=1:
  - A=-3 (16'hFFFD), B=5 -> Produto = 32'hFFFFFFF1.
  - A=B=16'h8000 -> 32'h40000000.
  - A=B=16'hFFFF -> 32'h00000001.
- W=16, sweep both modes:
  - A in {0, 1, 65530..65535}, B in {0, 1, 65530..65535}.
  - Produto must match the $signed or unsigned reference product in every case.
  - Exactly one Done pulse per St.
- Busy and stability, mid-CALC:
  - Assert St, change operands and toggle Signed_mode -> no restart; the result matches the captured operands.
  - Produto holds the previous value until edge W+1.
- Reset mid-operation:
  - Pulse Reset asynchronously (off a clock edge) at cycle 5 of CALC.
  - Immediately Idle = 1, Produto = 0, Done = 0.
  - No Done follows.
  - The next St computes correctly.
- Second instance, W=8:
  - Unsigned 255*255 -> 16'hFE01.
  - Signed -128*127 -> 16'hC080.
  - Done at edge 9 after capture.
